exec_mul_ctrl: RTL and testbench
================================

Name: exec_mul_ctrl

Overview:
Multi-cycle multiply sequencer sitting beside the EX-stage ALU. It accepts forwarded operands op1/op2 when a multiply instruction occupies ID/EX, then runs an iterative shift-add multiply for WIDTH cycles. During that time it asserts a stall that freezes PC, IF/ID and ID/EX. On completion it presents the 2*WIDTH-bit product for one cycle, to be captured into EX/MEM.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits
CNT_W, 5, iteration counter width; must equal clog2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  a multiply instruction is valid in ID/EX (decoded ctrl)
isSigned  input  1  1 = signed (two's complement) multiply, 0 = unsigned; sampled with start
op1  input  WIDTH  multiplicand, post-forwarding (output of the op1 forward mux)
op2  input  WIDTH  multiplier, post-forwarding (output of the op2 forward mux)
flush  input  1  branch/exception flush of ID/EX; aborts any operation
stall  output  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: product valid this cycle
resultLo  output  WIDTH  product bits [WIDTH-1:0]
resultHi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, accumulator=0, operand registers=0, negate flag=0. Outputs: stall=0, busy=0, done=0, resultLo=0, resultHi=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0: latch operands and go to RUN.
    - isSigned=1: latch |op1| and |op2|, negFlag = op1[MSB]^op2[MSB].
    - isSigned=0: latch raw values, negFlag=0.
    - Clear accumulator; counter=0.
  - In that same cycle stall=1, combinationally from start, so ID/EX holds.
- RUN, one multiplier bit per cycle:
  - if mplier[0], acc_hi += mcand (WIDTH+1-bit add, carry kept);
  - shift {carry, acc_hi, acc_lo/mplier} right by 1;
  - counter++.
  - After WIDTH RUN cycles (counter==WIDTH-1 at the edge), go to DONE.
  - stall=1 throughout.
- DONE, exactly one cycle:
  - done=1, stall=0, so the pipeline advances and EX/MEM captures the product.
  - If negFlag, output the two's complement of the 2*WIDTH product.
  - start is ignored here: ID/EX still holds the completed instruction.
  - Next state is IDLE.
- Latency: start seen in cycle 0, done in cycle WIDTH+1 (cycle 33 for WIDTH=32). stall is high for cycles 0..WIDTH, i.e. WIDTH+1 cycles.
- resultLo/resultHi are registered. They hold the last product until the next DONE or reset; they are valid for capture only when done=1.
- flush=1 in any state: next state IDLE, done suppressed, result registers unchanged. stall follows state (flush in IDLE with start=1 gives stall=0, no latch).
- Back-to-back multiplies: the second start is accepted in the IDLE cycle right after DONE.
- Edge cases: the most-negative operand (0x80000000) in signed mode takes |x| = 0x80000000 as unsigned, which is correct. A zero operand still takes the full WIDTH cycles; there is no early-out.
- Operand changes on op1/op2 after the start cycle are ignored.

Decomposition:
- Shared package exec_pkg:
  - state encoding constants MUL_IDLE=2'd0, MUL_RUN=2'd1, MUL_DONE=2'd2;
  - the WIDTH default;
  - the aluCtrl encoding, extended with the MUL opcode, so decode and this block agree.
- One natural sub-module: mul_datapath (operand/accumulator registers, adder, shifter, final negate). exec_mul_ctrl holds the FSM, counter and stall/done logic.

Test Plan:
- Unsigned: start with op1=7, op2=6, isSigned=0.
  - done asserts exactly 33 cycles after start.
  - resultLo=42, resultHi=0.
  - stall high for 33 cycles, then low in the DONE cycle.
- Signed: op1=0xFFFFFFFD (-3), op2=5, isSigned=1 → resultHi=0xFFFFFFFF, resultLo=0xFFFFFFF1 (-15). Same operands with isSigned=0 → resultHi=0x00000004, resultLo=0xFFFFFFF1.
- Extremes:
  - op1=op2=0xFFFFFFFF unsigned → resultHi=0xFFFFFFFE, resultLo=0x00000001.
  - op1=0x80000000, op2=0x80000000 signed → resultHi=0x40000000, resultLo=0.
- Flush mid-RUN: flush at cycle 10 → busy and stall drop next cycle, no done pulse, resultLo/resultHi keep their previous values. A new start then completes normally.
- Reset mid-RUN: drive rst=0 asynchronously at cycle 15 → stall, busy, done and results go to 0 immediately. After release, the FSM is in IDLE and start=0 keeps it there.
- Back-to-back: start held high through DONE with a new operand pair (3×4) following 2×2.
  - First done gives 4.
  - The start during DONE is not re-accepted.
  - The second done arrives 34 cycles after the first, with 12.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions.
//   - multiply sequencer state encodings
//   - default datapath width
//   - aluCtrl encoding, including the MUL opcode that selects exec_mul_ctrl
package exec_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MUL_IDLE,
        ST_RUN  = MUL_RUN,
        ST_DONE = MUL_DONE
    } mul_state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_MUL = 4'd9
    } alu_ctrl_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath.
//   i_clk, i_rst_n     clock, async active-low reset
//   i_load             latch operands (magnitudes in signed mode), clear accumulator
//   i_signed, i_op1/2  operand mode and values, used only with i_load
//   i_step             process one multiplier bit
//   i_capture          final step: register the (sign-corrected) product
//   o_res_lo/o_res_hi  registered product halves
module mul_datapath
    import exec_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_step,
    input  logic             i_capture,
    output logic [WIDTH-1:0] o_res_lo,
    output logic [WIDTH-1:0] o_res_hi
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_lo;      // multiplier bits shift out as product bits shift in
    logic               r_neg;

    logic [WIDTH-1:0]   w_op1_abs;
    logic [WIDTH-1:0]   w_op2_abs;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // The most-negative value negates to itself, which read as unsigned
    // is the correct magnitude.
    assign w_op1_abs = (i_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
    assign w_op2_abs = (i_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

    // Carry out of the add is kept and shifted into the accumulator MSB.
    assign w_sum      = {1'b0, r_acc_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt  = w_sum[WIDTH:1];
    assign w_lo_nxt   = {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_prod     = {w_acc_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            o_res_lo <= '0;
            o_res_hi <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= w_op1_abs;
                r_lo     <= w_op2_abs;
                r_acc_hi <= '0;
                r_neg    <= i_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
            end else if (i_step) begin
                r_acc_hi <= w_acc_nxt;
                r_lo     <= w_lo_nxt;
            end
            // Capture on the final step so the product is registered
            // and presented during the DONE cycle.
            if (i_capture) begin
                o_res_lo <= w_prod_fix[WIDTH-1:0];
                o_res_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: rtl/exec_mul_ctrl.sv
// Multi-cycle multiply sequencer beside the EX-stage ALU.
//   clk, rst            clock, async active-low reset
//   start, isSigned     multiply in ID/EX and its signedness
//   op1, op2            forwarded operands, sampled on the accepting cycle
//   flush               abort any operation, return to IDLE
//   stall               hold PC, IF/ID, ID/EX while the multiply runs
//   busy                sequencer not idle
//   done                one-cycle pulse, product valid on resultLo/resultHi
module exec_mul_ctrl
    import exec_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi
);

    mul_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_step;
    logic w_last;

    assign w_accept = rst && (r_state == ST_IDLE) && start && !flush;
    assign w_step   = (r_state == ST_RUN) && !flush;
    assign w_last   = w_step && (r_cnt == CNT_W'(WIDTH - 1));

    // Stall rises combinationally in the accepting cycle so ID/EX holds
    // the multiply; it drops in DONE so EX/MEM captures the product.
    assign stall = w_accept || (r_state == ST_RUN);
    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= ST_DONE;
                end
                // start is ignored: ID/EX still holds the finished multiply.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_load    (w_accept),
        .i_signed  (isSigned),
        .i_op1     (op1),
        .i_op2     (op2),
        .i_step    (w_step),
        .i_capture (w_last),
        .o_res_lo  (resultLo),
        .o_res_hi  (resultHi)
    );

endmodule

// File: tb/tb_exec_mul_ctrl.sv
module tb_exec_mul_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         isSigned;
    logic         flush;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] resultLo;
    logic [W-1:0] resultHi;

    exec_mul_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .isSigned (isSigned),
        .op1      (op1),
        .op2      (op2),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .resultLo (resultLo),
        .resultHi (resultHi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    logic [63:0] last_prod;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                m_e = sbq.pop_front();
                chk("product", {resultHi, resultLo}, m_e.prod);
                chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
            end
        end
    end

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [63:0] exp);
        int  n;
        bit  seen;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op1 = a; op2 = b; isSigned = s;
        e.prod = exp; e.cyc = cyc + 33;
        sbq.push_back(e);
        n = 0;
        @(negedge clk);
        if (stall) n++;
        @(posedge clk); #1;
        start = 1'b0; op1 = $urandom; op2 = $urandom; isSigned = ~s;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall) n++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("stall_at_done", 64'(stall), 64'd0);
            chk("stall_cycles", 64'(n), 64'd33);
        end
        last_prod = exp;
    endtask

    initial begin
        int  k;
        bit  seen;
        exp_t e;

        rst = 1'b0; start = 1'b0; isSigned = 1'b0; flush = 1'b0;
        op1 = '0; op2 = '0; last_prod = '0;

        repeat (2) @(negedge clk);
        chk("rst_stall",  64'(stall), 64'd0);
        chk("rst_busy",   64'(busy),  64'd0);
        chk("rst_done",   64'(done),  64'd0);
        chk("rst_result", {resultHi, resultLo}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Directed products
        run_mul(32'd7,        32'd6,        1'b0, 64'd42);
        run_mul(32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1);
        run_mul(32'hFFFFFFFD, 32'd5,        1'b0, 64'h00000004_FFFFFFF1);
        run_mul(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 64'd42);
        run_mul(32'd0,        32'h12345678, 1'b0, 64'd0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        run_mul(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);

        // Flush at cycle 10 of a multiply
        @(posedge clk); #1;
        start = 1'b1; op1 = 32'd9; op2 = 32'd9; isSigned = 1'b0;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < k + 10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("busy_before_flush", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",   64'(busy),  64'd0);
        chk("flush_stall",  64'(stall), 64'd0);
        chk("flush_result", {resultHi, resultLo}, last_prod);
        repeat (40) @(posedge clk);
        chk("flush_result_hold", {resultHi, resultLo}, last_prod);
        run_mul(32'd11, 32'd13, 1'b0, 64'd143);

        // Asynchronous reset mid-run
        @(posedge clk); #1;
        start = 1'b1; op1 = 32'd5; op2 = 32'd5; isSigned = 1'b0;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < k + 15) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_stall",  64'(stall), 64'd0);
        chk("arst_busy",   64'(busy),  64'd0);
        chk("arst_done",   64'(done),  64'd0);
        chk("arst_result", {resultHi, resultLo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy",  64'(busy),  64'd0);
        chk("post_rst_stall", 64'(stall), 64'd0);

        // Back-to-back: start held through DONE, 2x2 then 3x4
        @(posedge clk); #1;
        start = 1'b1; op1 = 32'd2; op2 = 32'd2; isSigned = 1'b0;
        k = cyc;
        e.prod = 64'd4;  e.cyc = k + 33; sbq.push_back(e);
        e.prod = 64'd12; e.cyc = k + 67; sbq.push_back(e);
        @(posedge clk); #1;
        op1 = 32'd3; op2 = 32'd4;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_first_done", 64'(seen), 64'd1);
        chk("b2b_stall_in_done", 64'(stall), 64'd0);
        @(negedge clk);
        chk("b2b_accept_stall", 64'(stall), 64'd1);
        chk("b2b_accept_busy",  64'(busy),  64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_second_done", 64'(seen), 64'd1);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
